// File: rtl/dm_pkg.sv
// Shared encodings and byte-lane helpers for the byte-addressable data memory.
package dm_pkg;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    WAIT = 2'd1,
    DONE = 2'd2
  } state_t;

  localparam logic [1:0] SZ_BYTE = 2'b00;
  localparam logic [1:0] SZ_HALF = 2'b01;
  localparam logic [1:0] SZ_WORD = 2'b10;
  localparam logic [1:0] SZ_BAD  = 2'b11;

  function automatic logic is_misaligned(input logic [1:0] size, input logic [1:0] lane);
    return (size == SZ_BAD) ||
           ((size == SZ_HALF) && lane[0]) ||
           ((size == SZ_WORD) && (lane != 2'b00));
  endfunction

  function automatic logic [3:0] lane_mask(input logic [1:0] size, input logic [1:0] lane);
    case (size)
      SZ_BYTE: return 4'b0001 << lane;
      SZ_HALF: return lane[1] ? 4'b1100 : 4'b0011;
      SZ_WORD: return 4'b1111;
      default: return 4'b0000;
    endcase
  endfunction

  // Replicate narrow store data across the word so every enabled lane sees it.
  function automatic logic [31:0] place_store(input logic [1:0] size, input logic [31:0] din);
    case (size)
      SZ_BYTE: return {4{din[7:0]}};
      SZ_HALF: return {2{din[15:0]}};
      default: return din;
    endcase
  endfunction

  function automatic logic [31:0] load_extend(input logic [31:0] word, input logic [1:0] size,
                                               input logic [1:0] lane, input logic sign);
    logic [31:0] sh;
    sh = word >> {lane, 3'b000};
    case (size)
      SZ_BYTE: return {{24{sign & sh[7]}}, sh[7:0]};
      SZ_HALF: return {{16{sign & sh[15]}}, sh[15:0]};
      default: return word;
    endcase
  endfunction

endpackage

// File: rtl/dm_byte_ram.sv
// Word-organised RAM with per-byte write enables and a registered read port.
module dm_byte_ram #(
  parameter int ADDR_W = 12
) (
  input  logic              clk,
  input  logic [3:0]        we,
  input  logic [ADDR_W-3:0] idx,
  input  logic [31:0]       wdata,
  output logic [31:0]       rdata
);

  logic [31:0] mem [2**(ADDR_W-2)];

  always_ff @(posedge clk) begin
    for (int i = 0; i < 4; i++) begin
      if (we[i]) mem[idx][8*i +: 8] <= wdata[8*i +: 8];
    end
    rdata <= mem[idx];
  end

endmodule

// File: rtl/dm_bytelane.sv
// Data memory front end: req/ready handshake, wait states, alignment check,
// byte-lane stores and sign/zero-extended loads.
module dm_bytelane
  import dm_pkg::*;
#(
  parameter int ADDR_W      = 12,
  parameter int WAIT_CYCLES = 0
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic              req,
  input  logic              we,
  input  logic [1:0]        size,
  input  logic              sign,
  input  logic [ADDR_W-1:0] addr,
  input  logic [31:0]       din,
  output logic              ready,
  output logic [31:0]       dout,
  output logic              misalign
);

  localparam logic [3:0] CNT_INIT = (WAIT_CYCLES > 0) ? 4'(WAIT_CYCLES - 1) : 4'd0;

  state_t state, next_state;
  logic [3:0]        cnt;
  logic              lat_we, lat_sign;
  logic [1:0]        lat_size;
  logic [ADDR_W-1:0] lat_addr;
  logic [31:0]       lat_din;
  logic [31:0]       dout_q;
  logic              misalign_q;

  logic              cur_we, cur_err, lat_err, accept, commit, load_done;
  logic [1:0]        cur_size;
  logic [ADDR_W-1:0] cur_addr;
  logic [31:0]       cur_din, ram_rdata, load_val;
  logic [3:0]        ram_we;

  // In IDLE the request is taken straight from the inputs so a zero-wait access
  // commits on its accept edge; afterwards the latched copy drives the RAM.
  always_comb begin
    if (state == IDLE) begin
      cur_we   = we;
      cur_size = size;
      cur_addr = addr;
      cur_din  = din;
    end else begin
      cur_we   = lat_we;
      cur_size = lat_size;
      cur_addr = lat_addr;
      cur_din  = lat_din;
    end
  end

  assign cur_err   = is_misaligned(cur_size, cur_addr[1:0]);
  assign lat_err   = is_misaligned(lat_size, lat_addr[1:0]);
  assign accept    = (state == IDLE) && req;
  assign commit    = rst_n && ((accept && ((WAIT_CYCLES == 0) || cur_err)) ||
                               ((state == WAIT) && (cnt == 4'd0)));
  assign ram_we    = (commit && cur_we && !cur_err) ? lane_mask(cur_size, cur_addr[1:0]) : 4'b0000;
  assign load_val  = load_extend(ram_rdata, lat_size, lat_addr[1:0], lat_sign);
  assign load_done = (state == DONE) && !lat_we && !lat_err;

  dm_byte_ram #(.ADDR_W(ADDR_W)) u_ram (
    .clk   (clk),
    .we    (ram_we),
    .idx   (cur_addr[ADDR_W-1:2]),
    .wdata (place_store(cur_size, cur_din)),
    .rdata (ram_rdata)
  );

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) state <= IDLE;
    else        state <= next_state;
  end

  always_comb begin
    next_state = state;
    case (state)
      IDLE: if (req) next_state = ((WAIT_CYCLES == 0) || cur_err) ? DONE : WAIT;
      WAIT: if (cnt == 4'd0) next_state = DONE;
      DONE: next_state = IDLE;
      default: next_state = IDLE;
    endcase
  end

  always_comb begin
    ready    = (state == DONE);
    misalign = misalign_q;
    dout     = load_done ? load_val : dout_q;
  end

  // Load data arrives from the RAM register during DONE and is captured as it leaves.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      cnt        <= 4'd0;
      lat_we     <= 1'b0;
      lat_sign   <= 1'b0;
      lat_size   <= SZ_BYTE;
      lat_addr   <= '0;
      lat_din    <= 32'd0;
      dout_q     <= 32'd0;
      misalign_q <= 1'b0;
    end else begin
      if (accept) begin
        lat_we   <= we;
        lat_sign <= sign;
        lat_size <= size;
        lat_addr <= addr;
        lat_din  <= din;
        cnt      <= CNT_INIT;
      end else if ((state == WAIT) && (cnt != 4'd0)) begin
        cnt <= cnt - 4'd1;
      end
      if (commit) begin
        misalign_q <= cur_err;
        if (cur_err) dout_q <= 32'd0;
      end
      if (load_done) dout_q <= load_val;
    end
  end

endmodule

// File: tb/tb_dm_bytelane.sv
// Randomised scoreboard bench: a byte-array reference model predicts every completion
// of a zero-wait and a three-wait instance.
module tb_dm_bytelane;

  typedef struct {
    int          dut;
    int          cyc;
    logic [31:0] dout;
    logic        mis;
  } exp_t;

  logic        clk = 1'b0;
  logic        rst_n = 1'b0;
  logic        req_s   [2];
  logic        we_s    [2];
  logic [1:0]  size_s  [2];
  logic        sign_s  [2];
  logic [11:0] addr_s  [2];
  logic [31:0] din_s   [2];
  logic        ready_s [2];
  logic [31:0] dout_s  [2];
  logic        mis_s   [2];

  int          cyc = 0;
  int          checks = 0;
  int          errors = 0;
  int          wcyc [2] = '{0, 3};
  exp_t        exp_q [$];
  exp_t        mon_e;
  logic [7:0]  ref_bytes [2][256];
  logic [31:0] last_dout [2];

  dm_bytelane #(.ADDR_W(12), .WAIT_CYCLES(0)) dut0 (
    .clk(clk), .rst_n(rst_n), .req(req_s[0]), .we(we_s[0]), .size(size_s[0]),
    .sign(sign_s[0]), .addr(addr_s[0]), .din(din_s[0]), .ready(ready_s[0]),
    .dout(dout_s[0]), .misalign(mis_s[0]));

  dm_bytelane #(.ADDR_W(12), .WAIT_CYCLES(3)) dut1 (
    .clk(clk), .rst_n(rst_n), .req(req_s[1]), .we(we_s[1]), .size(size_s[1]),
    .sign(sign_s[1]), .addr(addr_s[1]), .din(din_s[1]), .ready(ready_s[1]),
    .dout(dout_s[1]), .misalign(mis_s[1]));

  always #5 clk = ~clk;
  always @(posedge clk) cyc <= cyc + 1;

  task automatic checkOutput(input string name, input logic [31:0] act, input logic [31:0] req);
    checks++;
    if (act !== req) begin
      errors++;
      $display("[TB] FAIL %s actual=%h required=%h", name, act, req);
    end
  endtask

  // Reference model: memory as a flat byte array, results built with plain arithmetic.
  task automatic model_op(input int d, input logic w, input logic [1:0] sz, input logic sg,
                          input logic [11:0] a, input logic [31:0] data,
                          output logic [31:0] ed, output logic em);
    int n;
    logic [31:0] v;
    em = (sz == 2'd3) || (sz == 2'd1 && a[0]) || (sz == 2'd2 && a[1:0] != 2'd0);
    n  = (sz == 2'd0) ? 1 : (sz == 2'd1) ? 2 : 4;
    if (em) begin
      ed = 32'd0;
    end else if (w) begin
      for (int k = 0; k < n; k++) begin
        v = data >> (8 * k);
        ref_bytes[d][int'(a) + k] = v[7:0];
      end
      ed = last_dout[d];
    end else begin
      v = 32'd0;
      for (int k = 0; k < n; k++) v = v | (32'(ref_bytes[d][int'(a) + k]) << (8 * k));
      if (sg && n < 4 && v[8*n-1]) v = v | ~((32'h1 << (8 * n)) - 32'h1);
      ed = v;
    end
    last_dout[d] = ed;
  endtask

  task automatic pushExp(input int d, input int c, input logic [31:0] ed, input logic em);
    exp_t e;
    e.dut = d; e.cyc = c; e.dout = ed; e.mis = em;
    exp_q.push_back(e);
  endtask

  task automatic driveFields(input int d, input logic w, input logic [1:0] sz, input logic sg,
                             input logic [11:0] a, input logic [31:0] data);
    we_s[d] = w; size_s[d] = sz; sign_s[d] = sg; addr_s[d] = a; din_s[d] = data;
  endtask

  task automatic waitReady(input int d);
    bit seen = 0;
    for (int i = 0; i < 40 && !seen; i++) begin
      @(negedge clk);
      if (ready_s[d]) seen = 1;
    end
    if (!seen) begin
      checks++;
      errors++;
      $display("[TB] FAIL ready_timeout dut%0d actual=0 required=1", d);
    end
    @(posedge clk);
  endtask

  task automatic applyStimulus(input int d, input logic w, input logic [1:0] sz, input logic sg,
                               input logic [11:0] a, input logic [31:0] data);
    logic [31:0] ed;
    logic em;
    @(negedge clk);
    driveFields(d, w, sz, sg, a, data);
    req_s[d] = 1'b1;
    @(posedge clk);
    #1 req_s[d] = 1'b0;
    model_op(d, w, sz, sg, a, data, ed, em);
    pushExp(d, cyc + (em ? 0 : wcyc[d]), ed, em);
    waitReady(d);
  endtask

  // req held high across a completion is re-accepted two cycles after ready.
  task automatic heldReq();
    logic [31:0] ed, data;
    logic em;
    int n0;
    data = $urandom;
    @(negedge clk);
    driveFields(1, 1'b1, 2'd2, 1'b0, 12'h070, data);
    req_s[1] = 1'b1;
    @(posedge clk);
    #1 n0 = cyc;
    model_op(1, 1'b1, 2'd2, 1'b0, 12'h070, data, ed, em);
    pushExp(1, n0 + 3, ed, em);
    driveFields(1, 1'b0, 2'd1, 1'b1, 12'h072, 32'd0);
    model_op(1, 1'b0, 2'd1, 1'b1, 12'h072, 32'd0, ed, em);
    pushExp(1, n0 + 8, ed, em);
    repeat (5) @(posedge clk);
    #1 req_s[1] = 1'b0;
    waitReady(1);
  endtask

  // A request pulse while the memory is waiting must be dropped entirely.
  task automatic pulseInWait();
    logic [31:0] ed;
    logic em;
    @(negedge clk);
    driveFields(1, 1'b1, 2'd2, 1'b0, 12'h064, 32'h5A5A_0F0F);
    req_s[1] = 1'b1;
    @(posedge clk);
    #1 req_s[1] = 1'b0;
    model_op(1, 1'b1, 2'd2, 1'b0, 12'h064, 32'h5A5A_0F0F, ed, em);
    pushExp(1, cyc + 3, ed, em);
    @(negedge clk);
    driveFields(1, 1'b1, 2'd2, 1'b0, 12'h068, 32'hCAFE_F00D);
    req_s[1] = 1'b1;
    @(posedge clk);
    #1 req_s[1] = 1'b0;
    waitReady(1);
    applyStimulus(1, 1'b0, 2'd2, 1'b0, 12'h068, 32'd0);
    applyStimulus(1, 1'b0, 2'd2, 1'b0, 12'h064, 32'd0);
  endtask

  task automatic resetMidWait();
    applyStimulus(1, 1'b1, 2'd2, 1'b0, 12'h050, 32'h0000_0000);
    applyStimulus(1, 1'b1, 2'd2, 1'b0, 12'h010, 32'h0BAD_CAFE);
    applyStimulus(1, 1'b0, 2'd2, 1'b0, 12'h010, 32'd0);
    @(negedge clk);
    driveFields(1, 1'b1, 2'd2, 1'b0, 12'h050, 32'h1234_5678);
    req_s[1] = 1'b1;
    @(posedge clk);
    #1 req_s[1] = 1'b0;
    @(negedge clk);
    rst_n = 1'b0;
    #1;
    checkOutput("rst_ready", 32'(ready_s[1]), 32'd0);
    checkOutput("rst_dout", dout_s[1], 32'd0);
    checkOutput("rst_misalign", 32'(mis_s[1]), 32'd0);
    last_dout[0] = 32'd0;
    last_dout[1] = 32'd0;
    repeat (2) @(negedge clk);
    rst_n = 1'b1;
    applyStimulus(1, 1'b0, 2'd2, 1'b0, 12'h050, 32'd0);
  endtask

  always @(negedge clk) begin
    if (rst_n) begin
      for (int d = 0; d < 2; d++) begin
        if (ready_s[d]) begin
          if (exp_q.size() == 0) begin
            checks++;
            errors++;
            $display("[TB] FAIL unexpected_ready dut%0d actual=1 required=0", d);
          end else begin
            mon_e = exp_q.pop_front();
            checkOutput("completing_dut", 32'(d), 32'(mon_e.dut));
            checkOutput("ready_cycle", 32'(cyc), 32'(mon_e.cyc));
            checkOutput("dout", dout_s[d], mon_e.dout);
            checkOutput("misalign", 32'(mis_s[d]), 32'(mon_e.mis));
          end
        end
      end
    end
  end

  initial begin
    logic [1:0]  sz;
    logic [11:0] a;
    for (int d = 0; d < 2; d++) begin
      req_s[d] = 1'b0;
      driveFields(d, 1'b0, 2'd0, 1'b0, 12'h000, 32'd0);
      last_dout[d] = 32'd0;
    end
    @(negedge clk);
    for (int d = 0; d < 2; d++) begin
      checkOutput("reset_ready", 32'(ready_s[d]), 32'd0);
      checkOutput("reset_dout", dout_s[d], 32'd0);
      checkOutput("reset_misalign", 32'(mis_s[d]), 32'd0);
    end
    @(negedge clk);
    rst_n = 1'b1;

    for (int d = 0; d < 2; d++)
      for (int w = 0; w < 64; w++)
        applyStimulus(d, 1'b1, 2'd2, 1'b0, 12'(w * 4), $urandom);

    applyStimulus(0, 1'b1, 2'd2, 1'b0, 12'h010, 32'hDEAD_BEEF);
    applyStimulus(0, 1'b0, 2'd2, 1'b0, 12'h010, 32'd0);
    applyStimulus(0, 1'b1, 2'd2, 1'b0, 12'h010, 32'h1122_3344);
    applyStimulus(0, 1'b1, 2'd0, 1'b0, 12'h013, 32'hFFFF_FF80);
    applyStimulus(0, 1'b0, 2'd2, 1'b0, 12'h010, 32'd0);
    applyStimulus(0, 1'b0, 2'd0, 1'b1, 12'h013, 32'd0);
    applyStimulus(0, 1'b0, 2'd0, 1'b0, 12'h013, 32'd0);
    applyStimulus(0, 1'b1, 2'd2, 1'b0, 12'h020, 32'd0);
    applyStimulus(0, 1'b1, 2'd1, 1'b0, 12'h022, 32'h7777_A5A5);
    applyStimulus(0, 1'b0, 2'd2, 1'b0, 12'h020, 32'd0);
    applyStimulus(0, 1'b0, 2'd1, 1'b1, 12'h022, 32'd0);
    applyStimulus(0, 1'b0, 2'd2, 1'b0, 12'h011, 32'd0);
    applyStimulus(0, 1'b1, 2'd1, 1'b0, 12'h031, 32'hFFFF_FFFF);
    applyStimulus(0, 1'b1, 2'd3, 1'b0, 12'h040, 32'hFFFF_FFFF);
    applyStimulus(0, 1'b0, 2'd2, 1'b0, 12'h010, 32'd0);
    applyStimulus(0, 1'b0, 2'd2, 1'b0, 12'h030, 32'd0);
    applyStimulus(0, 1'b0, 2'd2, 1'b0, 12'h040, 32'd0);

    heldReq();
    pulseInWait();
    resetMidWait();

    for (int i = 0; i < 220; i++) begin
      sz = ($urandom_range(0, 9) == 0) ? 2'd3 : 2'($urandom_range(0, 2));
      a  = 12'($urandom_range(0, 255));
      if ($urandom_range(0, 3) != 0) begin
        if (sz == 2'd1) a[0] = 1'b0;
        if (sz == 2'd2) a[1:0] = 2'b00;
      end
      applyStimulus((i < 160) ? 0 : 1, 1'($urandom_range(0, 1)), sz, 1'($urandom_range(0, 1)),
                    a, $urandom);
    end

    repeat (4) @(negedge clk);
    checkOutput("pending_expectations", 32'(exp_q.size()), 32'd0);
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
